// File: rtl/coax_pkg.sv
// Shared definitions for the coax bit timer: state encoding and divisor clamp.
package coax_pkg;

    // Controller state for coax_bit_timer.
    typedef enum logic {
        COAX_BIT_TIMER_IDLE = 1'b0,
        COAX_BIT_TIMER_RUN  = 1'b1
    } coax_bit_timer_state_e;

    // Smallest divisor that still yields a distinct first and second half.
    localparam int unsigned COAX_MIN_DIV = 2;

    // Clamp a requested clocks-per-bit value to the usable range.
    function automatic int unsigned coax_clamp_div(input int unsigned n);
        return (n < COAX_MIN_DIV) ? COAX_MIN_DIV : n;
    endfunction

endpackage

// File: rtl/coax_bit_timer.sv
// Programmable bit-phase timer shared by the coax transmitter and receiver.
// Produces first/second-half phases, mid-bit and last-clock strobes, and a
// bit index within a word slot. The divisor is latched only at bit start,
// so rate changes take effect on the following bit. All outputs decode
// registered state only.
module coax_bit_timer
    import coax_pkg::*;
#(
    parameter int unsigned CLOCKS_PER_BIT = 8,
    parameter int unsigned DIV_WIDTH      = 5,
    parameter int unsigned BITS_PER_WORD  = 12
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enable,
    input  logic [DIV_WIDTH-1:0]             clocks_per_bit,
    input  logic                             restart,
    input  logic                             resync,
    output logic                             first_half,
    output logic                             second_half,
    output logic                             mid_clock,
    output logic                             last_clock,
    output logic                             word_last,
    output logic [$clog2(BITS_PER_WORD)-1:0] bit_index,
    output logic                             running
);

    localparam int unsigned BIT_W = $clog2(BITS_PER_WORD);

    localparam logic [DIV_WIDTH-1:0] RESET_DIV = DIV_WIDTH'(coax_clamp_div(CLOCKS_PER_BIT));
    localparam logic [DIV_WIDTH-1:0] DIV_ONE   = DIV_WIDTH'(1);
    localparam logic [BIT_W-1:0]     BIT_ONE   = BIT_W'(1);
    localparam logic [BIT_W-1:0]     LAST_BIT  = BIT_W'(BITS_PER_WORD - 1);

    coax_bit_timer_state_e state_q, state_d;
    logic [DIV_WIDTH-1:0]  count_q, count_d;
    logic [DIV_WIDTH-1:0]  div_q,   div_d;
    logic [BIT_W-1:0]      bit_q,   bit_d;

    logic [DIV_WIDTH-1:0]  div_in;
    logic [DIV_WIDTH-1:0]  half;
    logic                  is_run;
    logic                  at_last;

    // Clamped divisor candidate and per-bit decode of the latched divisor.
    always_comb begin
        div_in  = DIV_WIDTH'(coax_clamp_div(32'(clocks_per_bit)));
        half    = div_q >> 1;
        is_run  = (state_q == COAX_BIT_TIMER_RUN);
        at_last = (count_q == (div_q - DIV_ONE));
    end

    // Next-state logic; priority is enable drop, restart, resync, then counting.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        div_d   = div_q;
        bit_d   = bit_q;
        unique case (state_q)
            COAX_BIT_TIMER_IDLE: begin
                count_d = '0;
                bit_d   = '0;
                if (enable) begin
                    state_d = COAX_BIT_TIMER_RUN;
                    div_d   = div_in;
                end
            end
            COAX_BIT_TIMER_RUN: begin
                if (!enable) begin
                    state_d = COAX_BIT_TIMER_IDLE;
                    count_d = '0;
                    bit_d   = '0;
                end else if (restart) begin
                    count_d = '0;
                    bit_d   = '0;
                    div_d   = div_in;
                end else if (resync) begin
                    // Resync on the last clock pre-empts the wrap, so the bit
                    // index holds and the current divisor stays in force.
                    count_d = half;
                end else if (at_last) begin
                    count_d = '0;
                    div_d   = div_in;
                    bit_d   = (bit_q == LAST_BIT) ? '0 : (bit_q + BIT_ONE);
                end else begin
                    count_d = count_q + DIV_ONE;
                end
            end
            default: begin
                state_d = COAX_BIT_TIMER_IDLE;
                count_d = '0;
                bit_d   = '0;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= COAX_BIT_TIMER_IDLE;
            count_q <= '0;
            div_q   <= RESET_DIV;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
        end
    end

    // Output decode from registered state only.
    always_comb begin
        running     = is_run;
        first_half  = is_run && (count_q < half);
        second_half = is_run && (count_q >= half);
        mid_clock   = is_run && (count_q == half);
        last_clock  = is_run && at_last;
        word_last   = is_run && at_last && (bit_q == LAST_BIT);
        bit_index   = bit_q;
    end

endmodule

// File: tb/tb_coax_bit_timer.sv
// Directed bench for coax_bit_timer with a per-cycle expected-output queue.
module tb_coax_bit_timer;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [4:0] clocks_per_bit;
    logic       restart;
    logic       resync;
    logic       first_half;
    logic       second_half;
    logic       mid_clock;
    logic       last_clock;
    logic       word_last;
    logic [3:0] bit_index;
    logic       running;

    always #5 clk = ~clk;

    coax_bit_timer #(
        .CLOCKS_PER_BIT(8),
        .DIV_WIDTH     (5),
        .BITS_PER_WORD (12)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .clocks_per_bit(clocks_per_bit),
        .restart       (restart),
        .resync        (resync),
        .first_half    (first_half),
        .second_half   (second_half),
        .mid_clock     (mid_clock),
        .last_clock    (last_clock),
        .word_last     (word_last),
        .bit_index     (bit_index),
        .running       (running)
    );

    typedef struct {
        logic       fh;
        logic       sh;
        logic       mid;
        logic       last;
        logic       wl;
        logic       run;
        logic [3:0] bi;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference state of the timer as the bench understands it.
    bit          m_run;
    int unsigned m_cnt;
    int unsigned m_bit;
    int unsigned m_n;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic void model_reset();
        m_run = 1'b0;
        m_cnt = 0;
        m_bit = 0;
        m_n   = 8;
    endfunction

    function automatic void model_edge();
        int unsigned ne;
        ne = (clocks_per_bit < 5'd2) ? 2 : int'(clocks_per_bit);
        if (!m_run) begin
            if (enable) begin
                m_run = 1'b1;
                m_cnt = 0;
                m_bit = 0;
                m_n   = ne;
            end
        end else if (!enable) begin
            m_run = 1'b0;
            m_cnt = 0;
            m_bit = 0;
        end else if (restart) begin
            m_cnt = 0;
            m_bit = 0;
            m_n   = ne;
        end else if (resync) begin
            m_cnt = m_n / 2;
        end else if (m_cnt == m_n - 1) begin
            m_cnt = 0;
            m_bit = (m_bit == 11) ? 0 : m_bit + 1;
            m_n   = ne;
        end else begin
            m_cnt = m_cnt + 1;
        end
    endfunction

    function automatic void push_expected();
        exp_t        e;
        int unsigned h;
        h      = m_n / 2;
        e.run  = m_run;
        e.fh   = m_run && (m_cnt < h);
        e.sh   = m_run && (m_cnt >= h);
        e.mid  = m_run && (m_cnt == h);
        e.last = m_run && (m_cnt == m_n - 1);
        e.wl   = e.last && (m_bit == 11);
        e.bi   = 4'(m_bit);
        sb_q.push_back(e);
    endfunction

    task automatic compare_pop(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk({tag, ".queue_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk({tag, ".first_half"},  first_half,  e.fh);
            chk({tag, ".second_half"}, second_half, e.sh);
            chk({tag, ".mid_clock"},   mid_clock,   e.mid);
            chk({tag, ".last_clock"},  last_clock,  e.last);
            chk({tag, ".word_last"},   word_last,   e.wl);
            chk({tag, ".running"},     running,     e.run);
            chk({tag, ".bit_index"},   bit_index,   e.bi);
        end
    endtask

    // One clock: advance the reference on the edge, then compare 1 ns later.
    task automatic step(input string tag);
        @(posedge clk);
        if (reset) model_edge();
        push_expected();
        #1;
        compare_pop(tag);
    endtask

    // Step until last_clock is seen or the budget runs out.
    task automatic run_until_last(input string tag, input int budget,
                                  output int steps, output int mid_at);
        steps  = 0;
        mid_at = 0;
        do begin
            step(tag);
            steps++;
            if (mid_clock && mid_at == 0) mid_at = steps;
        end while (!last_clock && steps < budget);
        chk({tag, ".last_seen"}, last_clock, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fh_n, sh_n, mid_n, last_n, wl_n, wl_first, wl_second;
        int steps, mid_at;
        int unsigned rb;

        reset          = 1'b0;
        enable         = 1'b0;
        restart        = 1'b0;
        resync         = 1'b0;
        clocks_per_bit = 5'd8;
        model_reset();
        #2;
        push_expected();
        compare_pop("reset_hold");
        for (int i = 0; i < 3; i++) step("reset_hold");

        // Release with enable low: stays idle.
        reset = 1'b1;
        for (int i = 0; i < 10; i++) step("idle");
        chk("idle.running", running, 1'b0);
        chk("idle.bit_index", bit_index, 4'd0);

        // Steady run at N=8 across two full words.
        enable    = 1'b1;
        fh_n      = 0;
        sh_n      = 0;
        mid_n     = 0;
        last_n    = 0;
        wl_n      = 0;
        wl_first  = 0;
        wl_second = 0;
        for (int i = 1; i <= 192; i++) begin
            step("run8");
            if (i == 1) begin
                chk("start.running", running, 1'b1);
                chk("start.first_half", first_half, 1'b1);
            end
            if (i == 96) chk("wrap.bit11", bit_index, 4'd11);
            if (i == 97) chk("wrap.bit0", bit_index, 4'd0);
            fh_n   += int'(first_half);
            sh_n   += int'(second_half);
            mid_n  += int'(mid_clock);
            last_n += int'(last_clock);
            if (word_last) begin
                wl_n++;
                if (wl_first == 0) wl_first = i;
                else wl_second = i;
            end
        end
        chk("run8.fh_cycles", fh_n, 96);
        chk("run8.sh_cycles", sh_n, 96);
        chk("run8.mid_count", mid_n, 24);
        chk("run8.last_count", last_n, 24);
        chk("run8.word_last_count", wl_n, 2);
        chk("run8.word_last_first", wl_first, 96);
        chk("run8.word_period", wl_second - wl_first, 96);

        // Rate change 8 -> 6 at count 3: current bit keeps 8 clocks.
        for (int i = 0; i < 4; i++) step("rate_pre");
        clocks_per_bit = 5'd6;
        run_until_last("rate_cur", 20, steps, mid_at);
        chk("rate.cur_remaining", steps, 4);
        run_until_last("rate_next", 20, steps, mid_at);
        chk("rate.next_len", steps, 6);
        chk("rate.next_mid_at", mid_at, 4);

        // Resync at count 1 of an N=8 bit.
        clocks_per_bit = 5'd8;
        step("resync_pre");
        step("resync_pre");
        resync = 1'b1;
        step("resync1");
        resync = 1'b0;
        chk("resync1.mid", mid_clock, 1'b1);
        run_until_last("resync1_tail", 20, steps, mid_at);
        chk("resync1.last_after", steps, 3);

        // Resync on the last clock: bit index must hold.
        step("resync7_pre");
        rb = m_bit;
        for (int i = 0; i < 7; i++) step("resync7_pre");
        chk("resync7.at_last", last_clock, 1'b1);
        resync = 1'b1;
        step("resync7");
        resync = 1'b0;
        chk("resync7.mid", mid_clock, 1'b1);
        chk("resync7.bit_hold", bit_index, 4'(rb));
        chk("resync7.second_half", second_half, 1'b1);

        // Restart at bit 5, with resync asserted too (restart wins).
        for (int i = 0; i < 200 && m_bit != 5; i++) step("to_bit5");
        chk("restart.pre_bit", bit_index, 4'd5);
        restart = 1'b1;
        resync  = 1'b1;
        step("restart");
        restart = 1'b0;
        resync  = 1'b0;
        chk("restart.bit_index", bit_index, 4'd0);
        chk("restart.first_half", first_half, 1'b1);
        chk("restart.mid", mid_clock, 1'b0);

        // Odd divisor N=5: halves of 2 and 3 clocks.
        clocks_per_bit = 5'd5;
        restart = 1'b1;
        step("odd5");
        restart = 1'b0;
        fh_n = int'(first_half);
        sh_n = int'(second_half);
        for (int i = 0; i < 4; i++) begin
            step("odd5");
            fh_n += int'(first_half);
            sh_n += int'(second_half);
        end
        chk("odd5.fh_cycles", fh_n, 2);
        chk("odd5.sh_cycles", sh_n, 3);
        chk("odd5.last", last_clock, 1'b1);
        run_until_last("odd5_next", 20, steps, mid_at);
        chk("odd5.bit_len", steps, 5);
        chk("odd5.mid_at", mid_at, 3);

        // Clamp: 0 and 1 both give 2-clock bits, mid coincides with last.
        clocks_per_bit = 5'd0;
        restart = 1'b1;
        step("clamp0");
        restart = 1'b0;
        chk("clamp0.first_half", first_half, 1'b1);
        run_until_last("clamp0", 10, steps, mid_at);
        chk("clamp0.tail", steps, 1);
        chk("clamp0.mid_eq_last", mid_at, 1);
        run_until_last("clamp0_b", 10, steps, mid_at);
        chk("clamp0.bit_len", steps, 2);
        clocks_per_bit = 5'd1;
        run_until_last("clamp1", 10, steps, mid_at);
        chk("clamp1.bit_len", steps, 2);
        chk("clamp1.mid_eq_last", mid_at, 2);

        // Enable drop mid-bit, then re-enable from bit 0.
        clocks_per_bit = 5'd8;
        restart = 1'b1;
        step("endrop_pre");
        restart = 1'b0;
        for (int i = 0; i < 5; i++) step("endrop_pre");
        enable = 1'b0;
        step("endrop");
        chk("endrop.running", running, 1'b0);
        chk("endrop.second_half", second_half, 1'b0);
        enable = 1'b1;
        step("reenable");
        chk("reenable.bit_index", bit_index, 4'd0);
        chk("reenable.first_half", first_half, 1'b1);

        // Asynchronous reset mid-bit.
        for (int i = 0; i < 5; i++) step("rst_pre");
        reset = 1'b0;
        model_reset();
        #1;
        push_expected();
        compare_pop("async_rst");
        chk("async_rst.running", running, 1'b0);
        chk("async_rst.second_half", second_half, 1'b0);
        enable = 1'b0;
        step("rst_hold");
        step("rst_hold");
        reset = 1'b1;
        step("post_rst_idle");
        step("post_rst_idle");
        chk("post_rst.running", running, 1'b0);
        enable = 1'b1;
        step("post_rst_run");
        chk("post_rst.running_on", running, 1'b1);

        chk("scoreboard.drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
